instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the instruction decoder. Owns the PC and issues word reads to instruction memory.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used as instruction buffer and PC-tag queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_i) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers responses
// and drops responses that belong to fetches made stale by a redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int TW = $clog2(MAX_OUTST) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            req_fire, rsp_fire, drop_rsp;
    logic            buf_push, buf_pop, buf_full, buf_empty;
    logic [CW-1:0]   buf_count;
    fetch_entry_t    buf_din, buf_dout;
    logic [XLEN-1:0] tag_head;
    logic            tag_full, tag_empty;
    logic [TW-1:0]   tag_count;
    logic [CW:0]     used_slots;

    // Credit counts slots already owed to in-flight requests, so a response always fits.
    assign used_slots     = {1'b0, outst_q} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !redirect_valid
                            && (used_slots < (CW+1)'(BUF_DEPTH))
                            && (outst_q < CW'(MAX_OUTST));
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outst_q != '0);
    assign drop_rsp = rsp_fire && (drop_q != '0);
    assign buf_push = rsp_fire && !drop_rsp && !redirect_valid;
    assign buf_din  = '{ins: imem_rsp_data, pc: tag_head};

    assign ins_valid = !buf_empty && !redirect_valid;
    assign buf_pop   = ins_valid && ins_ready;
    assign ins       = buf_dout.ins;
    assign ins_pc    = buf_dout.pc;

    assign outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);

    always_comb begin
        drop_d = drop_q;
        pc_d   = pc_q;
        if (redirect_valid) begin
            drop_d = outst_d;
            pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (drop_rsp) drop_d = drop_q - CW'(1);
            if (req_fire) pc_d = pc_q + XLEN'(INSN_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_ins_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (buf_push),
        .din_i   (buf_din),
        .pop_i   (buf_pop),
        .flush_i (redirect_valid),
        .dout_o  (buf_dout),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    // Tags follow the in-order response stream, so they are never flushed.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .din_i   (pc_q),
        .pop_i   (rsp_fire),
        .flush_i (1'b0),
        .dout_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    a_rsp_tracked:  assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && outst_q == '0));
    a_addr_align:   assert property (@(posedge clk) disable iff (rst) imem_req_valid |-> imem_req_addr[1:0] == 2'b00);
    a_tag_sync:     assert property (@(posedge clk) disable iff (rst) int'(tag_count) == int'(outst_q));
    a_tag_nonempty: assert property (@(posedge clk) disable iff (rst) !(rsp_fire && tag_empty));
    a_tag_room:     assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
    a_buf_room:     assert property (@(posedge clk) disable iff (rst) !(buf_push && buf_full && !buf_pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order latency memory model plus a scoreboard of expected deliveries.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers each accepted request exactly lat cycles later, in order.
    always @(posedge clk) begin
        #2;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: a redirect or reset invalidates everything fetched before it.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            exp_q.delete();
        end else begin
            if (redirect_valid) exp_q.delete();
            if (ins_valid && ins_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc=%h ins=%h, expected no delivery", ins_pc, ins);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({ins, ins_pc} !== exp_e) begin
                        errors++;
                        $display("FAIL sb_data: got pc=%h ins=%h, expected pc=%h ins=%h",
                                 ins_pc, ins, exp_e[31:0], exp_e[63:32]);
                    end
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + lat});
                exp_q.push_back({mem_word(imem_req_addr), imem_req_addr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        step();
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ins_valid !== 1'b0)      begin errors++; $display("FAIL rst_ins_valid: got %b want 0", ins_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (ins !== 32'h0)           begin errors++; $display("FAIL rst_ins: got %h want 0", ins); end
        checks++; if (ins_pc !== 32'h0)        begin errors++; $display("FAIL rst_ins_pc: got %h want 0", ins_pc); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_fetch_order();
        logic [31:0] addrs[$];
        int first_ins = -1;
        logic req1 = 1'b0;
        lat = 1;
        do_reset(2);
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) req1 = imem_req_valid && imem_req_ready;
            if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
            if (ins_valid && first_ins < 0) begin
                first_ins = k;
                checks++;
                if ({ins_pc, ins} !== {32'h0, mem_word(32'h0)}) begin
                    errors++; $display("FAIL order_first_ins: got pc=%h ins=%h want pc=0 ins=%h", ins_pc, ins, mem_word(32'h0));
                end
            end
        end
        checks++; if (first_ins != 2) begin errors++; $display("FAIL order_latency: got cycle %0d want 2", first_ins); end
        checks++; if (req1 !== 1'b1)  begin errors++; $display("FAIL order_second_req: got %b want 1", req1); end
        checks++;
        if (addrs.size() < 3) begin
            errors++; $display("FAIL order_addrs: got %0d requests want >=3", addrs.size());
        end else if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            errors++; $display("FAIL order_addrs: got %h %h %h want 0 4 8", addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        lat = 1;
        ins_ready = 1'b0;
        do_reset(2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        checks++; if (n != 2)                  begin errors++; $display("FAIL bp_req_count: got %0d want 2", n); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b want 0", imem_req_valid); end
        checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", ins_valid, ins_pc);
        end
        step();
        ins_ready = 1'b1;
        @(negedge clk);
        checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || ins !== mem_word(32'h0)) begin
            errors++; $display("FAIL bp_release0: got valid=%b pc=%h ins=%h want pc=0", ins_valid, ins_pc, ins);
        end
        @(negedge clk);
        checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h4) begin
            errors++; $display("FAIL bp_release1: got valid=%b pc=%h want pc=4", ins_valid, ins_pc);
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] want);
        logic found = 1'b0;
        logic [31:0] got = '0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin found = 1'b1; got = imem_req_addr; end
        end
        checks++;
        if (!found || got !== want) begin
            errors++; $display("FAIL %s_next_addr: got found=%b addr=%h want %h", name, found, got, want);
        end
    endtask

    task automatic wait_ins(input string name, input logic [31:0] want_pc);
        logic found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (ins_valid) found = 1'b1;
        end
        checks++;
        if (!found || ins_pc !== want_pc || ins !== mem_word(want_pc)) begin
            errors++; $display("FAIL %s_first_ins: got found=%b pc=%h ins=%h want pc=%h", name, found, ins_pc, ins, want_pc);
        end
    endtask

    task automatic test_redirect_drop();
        lat = 3;
        do_reset(2);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_req_in_redirect: got %b want 0", imem_req_valid); end
        checks++; if (ins_valid !== 1'b0)      begin errors++; $display("FAIL drop_ins_in_redirect: got %b want 0", ins_valid); end
        step();
        redirect_valid = 1'b0;
        wait_req("drop", 32'h100);
        wait_ins("drop", 32'h100);
    endtask

    task automatic test_redirect_collide();
        lat = 1;
        do_reset(2);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL coll_req: got %b want 0", imem_req_valid); end
        checks++; if (ins_valid !== 1'b0)      begin errors++; $display("FAIL coll_ins_valid: got %b want 0", ins_valid); end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL coll_next_addr: got valid=%b addr=%h want 1/200", imem_req_valid, imem_req_addr);
        end
        wait_ins("coll", 32'h200);
    endtask

    task automatic test_pc_wrap();
        logic [31:0] pcs[$];
        lat = 1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_req("wrap0", 32'hFFFF_FFFC);
        wait_req("wrap1", 32'h0000_0000);
        for (int k = 0; k < 20 && pcs.size() < 2; k++) begin
            @(negedge clk);
            if (ins_valid && ins_ready) pcs.push_back(ins_pc);
        end
        checks++;
        if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_tags: got %0d deliveries, expected pcs FFFFFFFC then 0", pcs.size());
        end
    endtask

    task automatic test_back_to_back();
        lat = 3;
        do_reset(2);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_pc    = 32'h400;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_req: got %b want 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        wait_req("b2b", 32'h400);
        wait_ins("b2b", 32'h400);
    endtask

    task automatic test_reset_midstream();
        lat = 1;
        ins_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got ins_valid=%b want 1", ins_valid); end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_in_rst: got %b want 0", imem_req_valid); end
        step();
        @(negedge clk);
        checks++; if (ins_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after_rst: got ins_valid=%b req_valid=%b want 0/0", ins_valid, imem_req_valid);
        end
        step();
        rst = 1'b0;
        ins_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL mid_first_addr: got valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
        end
        wait_ins("mid", 32'h0);
    endtask

    initial begin
        test_reset();
        test_fetch_order();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_pc_wrap();
        test_back_to_back();
        test_reset_midstream();
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
